mult_stream_adapter: RTL

- Ready/valid stream front end for the pipelined 64x64 multiplier (`mult_64x64_seg`).
- Upstream side: accepts operand pairs and issues them to the multiplier as single-cycle start pulses.
- Downstream side: captures each done/result pair into an output FIFO and presents results in order on a ready/valid stream.
- The multiplier has no stall input, so the adapter limits issue with a credit count. This guarantees every in-flight product has a FIFO slot.

---
 rtl/mult_stream_adapter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mult_stream_adapter.sv
// Ready/valid front end for the pipelined 64x64 multiplier: issues operand pairs, collects products in order.
// Latency: accept at edge T -> out_valid in the cycle after edge T+8 (7-cycle multiplier + issue + capture).
// Backpressure: in_ready is registered and credit-limited so every in-flight product owns a FIFO slot; never combinational on out_ready.
//
// Ports:
//   clk, rst_n                  - single clock, synchronous active-low reset
//   in_valid/in_ready/in_a/in_b - operand stream in
//   mult_rst/mult_start/mult_a/mult_b/mult_result/mult_done - multiplier side
//   out_valid/out_ready/out_result - product stream out (in issue order)
//   err_overflow                - sticky: done with nothing in flight, or done with FIFO full
// Optional: define MULT_ADAPT_TAG_EN to add in_tag/out_tag, carried alongside each product.
module mult_stream_adapter #(
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [63:0]    in_a,
  input  logic [63:0]    in_b,
  output logic           mult_rst,
  output logic           mult_start,
  output logic [63:0]    mult_a,
  output logic [63:0]    mult_b,
  input  logic [127:0]   mult_result,
  input  logic           mult_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_result,
  output logic           err_overflow
`ifdef MULT_ADAPT_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TAG_W < 1) begin : g_bad_params
    $error("mult_stream_adapter: FIFO_DEPTH must be a power of 2 >= 2 and TAG_W >= 1");
  end

  logic [CW-1:0]  credits, credits_nxt;
  logic [CW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt, in_flight;
  logic [127:0]   res_mem [FIFO_DEPTH];
  logic           accept, pop;
  logic           fifo_full, fifo_empty;
  logic           tq_empty;
  logic           done_bad, wr_en;

  assign accept     = in_valid & in_ready;
  assign fifo_empty = (wr_ptr == rd_ptr);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid & out_ready;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  // Credits cover stored plus in-flight products; the difference is what the multiplier still owes us.
  assign in_flight  = credits - fifo_cnt;

  assign credits_nxt = credits + CW'(accept) - CW'(pop);

  // A done we cannot account for is flagged and discarded rather than corrupting the FIFO.
  assign done_bad = mult_done & (fifo_full | (in_flight == '0) | tq_empty);
  assign wr_en    = mult_done & ~done_bad;

  assign out_result = out_valid ? res_mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mult_rst     <= 1'b1;
      in_ready     <= 1'b0;
      mult_start   <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      credits      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      mult_rst   <= 1'b0;
      // Uses the post-edge credit count so in_ready drops on the edge that takes the last slot.
      // Held low for the cycle the multiplier is still leaving reset.
      in_ready   <= !mult_rst && (credits_nxt < CW'(FIFO_DEPTH));
      mult_start <= accept;
      if (accept) begin
        mult_a <= in_a;
        mult_b <= in_b;
      end
      credits <= credits_nxt;
      if (wr_en) wr_ptr <= wr_ptr + CW'(1);
      if (pop)   rd_ptr <= rd_ptr + CW'(1);
      if (done_bad) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) res_mem[wr_ptr[AW-1:0]] <= mult_result;
  end

`ifdef MULT_ADAPT_TAG_EN
  // Tags wait here while their product is inside the multiplier, then move into the
  // result FIFO with it. Depth matches the credit limit, so this queue cannot overflow.
  logic [TAG_W-1:0] tq_mem  [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
  logic [CW-1:0]    tq_wr, tq_rd;

  assign tq_empty = (tq_wr == tq_rd);
  assign out_tag  = out_valid ? tag_mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tq_wr <= '0;
      tq_rd <= '0;
    end else begin
      if (accept) tq_wr <= tq_wr + CW'(1);
      // Pop on every done so the queue stays aligned with the multiplier, even if the write is dropped.
      if (mult_done && !tq_empty) tq_rd <= tq_rd + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tq_mem[tq_wr[AW-1:0]] <= in_tag;
    if (wr_en)  tag_mem[wr_ptr[AW-1:0]] <= tq_mem[tq_rd[AW-1:0]];
  end
`else
  assign tq_empty = 1'b0;
`endif

endmodule
